// File: rtl/wd_pkg.sv
// ============================================================================
// Module      : wd_pkg
// Description : Shared defaults, FSM state encoding and lane-value helper for
//               the stream driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wd_pkg;

    localparam int c_def_ways    = 8;
    localparam int c_def_lane_w  = 8;
    localparam int c_def_streams = 4;
    localparam int c_def_max_len = 16;
    localparam int c_def_qdepth  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wd_state_t;

    // Value carried by lane k of a beat whose stream counter is seq; callers
    // truncate to the lane width, which gives the modulo wrap for free.
    function automatic logic [31:0] lane_val(
        input logic [31:0] seq,
        input logic [31:0] ways,
        input logic [31:0] k
    );
        return (seq * ways) + k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wd_req_fifo.sv
// ============================================================================
// Module      : wd_req_fifo
// Description : Show-ahead request FIFO with registered full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wd_req_fifo #(
    parameter  int WIDTH   = 8,
    parameter  int DEPTH   = 4,
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int c_cnt_w = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    // A full FIFO refuses a push even when the same edge pops an entry.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wd_stream_driver.sv
// ============================================================================
// Module      : wd_stream_driver
// Description : Queues {stream, length} requests and plays each out as a burst
//               of multi-lane data beats built from per-stream counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wd_stream_driver
    import wd_pkg::*;
#(
    parameter  int WAYS     = c_def_ways,
    parameter  int LANE_W   = c_def_lane_w,
    parameter  int STREAMS  = c_def_streams,
    parameter  int MAX_LEN  = c_def_max_len,
    parameter  int QDEPTH   = c_def_qdepth,
    localparam int c_sid_w  = (STREAMS > 1) ? $clog2(STREAMS) : 1,
    localparam int c_len_w  = $clog2(MAX_LEN + 1),
    localparam int c_data_w = WAYS * LANE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_v,
    output logic                i_r,
    input  logic [c_sid_w-1:0]  i_sid,
    input  logic [c_len_w-1:0]  i_len,
    output logic                o_v,
    input  logic                o_r,
    output logic [c_data_w-1:0] o_d,
    output logic [c_sid_w-1:0]  o_sid,
    output logic                o_last
);

    localparam int c_fifo_w = c_sid_w + c_len_w;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_xfer;
    logic                w_load;
    logic [c_fifo_w-1:0] w_head;
    logic [c_sid_w-1:0]  w_head_sid;
    logic [c_len_w-1:0]  w_head_len;
    logic [c_len_w-1:0]  w_len_clamped;
    logic [c_sid_w-1:0]  w_load_sid;
    logic [LANE_W-1:0]   w_load_seq;
    logic [c_data_w-1:0] w_load_word;

    wd_state_t           r_state;
    logic                r_armed;
    logic [c_sid_w-1:0]  r_sid;
    logic [c_len_w-1:0]  r_rem;
    logic [LANE_W-1:0]   r_seq [STREAMS];
    logic                r_o_v;
    logic                r_o_last;
    logic [c_data_w-1:0] r_o_d;

    // r_armed keeps the request port closed until the first edge after reset.
    assign i_r           = r_armed && !w_full;
    assign w_push        = i_v && i_r;
    assign w_len_clamped = (i_len > c_len_w'(MAX_LEN)) ? c_len_w'(MAX_LEN) : i_len;

    wd_req_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({i_sid, w_len_clamped}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_sid, w_head_len} = w_head;

    assign w_xfer = r_o_v && o_r;
    assign w_pop  = !w_empty &&
                    ((r_state == IDLE) || (w_xfer && (r_rem == c_len_w'(1))));
    assign w_load = w_pop && (w_head_len != '0);

    // Counter value for the next beat shown: when the new burst targets the
    // stream that is transferring this edge, use the post-increment value.
    assign w_load_sid = w_load ? w_head_sid : r_sid;
    assign w_load_seq = (w_xfer && (w_load_sid == r_sid)) ?
                        r_seq[r_sid] + LANE_W'(1) : r_seq[w_load_sid];

    for (genvar k = 0; k < WAYS; k++) begin : g_lane
        assign w_load_word[k*LANE_W +: LANE_W] =
            LANE_W'(lane_val(32'(w_load_seq), 32'(WAYS), 32'(k)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_armed  <= 1'b0;
            r_sid    <= '0;
            r_rem    <= '0;
            r_o_v    <= 1'b0;
            r_o_last <= 1'b0;
            r_o_d    <= '0;
            for (int s = 0; s < STREAMS; s++) begin
                r_seq[s] <= '0;
            end
        end else begin
            r_armed <= 1'b1;
            if (w_xfer) begin
                r_seq[r_sid] <= r_seq[r_sid] + LANE_W'(1);
            end
            if (w_load) begin
                r_state  <= BURST;
                r_sid    <= w_head_sid;
                r_rem    <= w_head_len;
                r_o_v    <= 1'b1;
                r_o_last <= (w_head_len == c_len_w'(1));
                r_o_d    <= w_load_word;
            end else if (w_xfer) begin
                if (r_rem == c_len_w'(1)) begin
                    r_state  <= IDLE;
                    r_o_v    <= 1'b0;
                    r_o_last <= 1'b0;
                end else begin
                    r_rem    <= r_rem - c_len_w'(1);
                    r_o_last <= (r_rem == c_len_w'(2));
                    r_o_d    <= w_load_word;
                end
            end
        end
    end

    assign o_v    = r_o_v;
    assign o_d    = r_o_d;
    assign o_sid  = r_sid;
    assign o_last = r_o_last;

endmodule

`default_nettype wire

// File: tb/tb_wd_stream_driver.sv
// ============================================================================
// Module      : tb_wd_stream_driver
// Description : Directed, table-driven bench for wd_stream_driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wd_stream_driver;

    localparam logic [63:0] c_w0 = 64'h0706050403020100;
    localparam logic [63:0] c_w1 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] c_w2 = 64'h1716151413121110;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_v   = 1'b0;
    logic        i_r;
    logic [1:0]  i_sid = 2'd0;
    logic [4:0]  i_len = 5'd0;
    logic        o_v;
    logic        o_r   = 1'b0;
    logic [63:0] o_d;
    logic [1:0]  o_sid;
    logic        o_last;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        v;
        logic [1:0]  sid;
        logic [4:0]  len;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_d;
        logic [1:0]  e_sid;
        logic        e_last;
    } vec_t;

    vec_t tbl [16];

    always #5 clk = ~clk;

    wd_stream_driver #(
        .WAYS    (8),
        .LANE_W  (8),
        .STREAMS (4),
        .MAX_LEN (16),
        .QDEPTH  (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_v    (i_v),
        .i_r    (i_r),
        .i_sid  (i_sid),
        .i_len  (i_len),
        .o_v    (o_v),
        .o_r    (o_r),
        .o_d    (o_d),
        .o_sid  (o_sid),
        .o_last (o_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference word: lane k = (s*8 + k) mod 256.
    function automatic logic [63:0] word_of(input int s);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[k*8 +: 8] = 8'((s * 8 + k) & 255);
        end
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc;
        int          beats;
        int          lasts;
        int          first_c;
        int          last_c;
        logic [63:0] dcap;
        logic [63:0] d32;
        logic [63:0] d33;
        logic [1:0]  scap;
        logic        l16;
        logic        l33;

        //           v     sid   len   ordy  e_ir  e_ov  e_d    e_sid e_last
        tbl[0]  = '{1'b1, 2'd0, 5'd1, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b1, c_w0,  2'd0, 1'b1};
        tbl[3]  = '{1'b1, 2'd0, 5'd2, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b1, c_w1,  2'd0, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b1, c_w2,  2'd0, 1'b1};
        tbl[7]  = '{1'b1, 2'd1, 5'd3, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b1, c_w0,  2'd1, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, c_w1,  2'd1, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, c_w1,  2'd1, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, c_w1,  2'd1, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b1, c_w1,  2'd1, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b1, c_w2,  2'd1, 1'b1};
        tbl[15] = '{1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst.i_r",    64'(i_r),    64'd0);
        chk("rst.o_v",    64'(o_v),    64'd0);
        chk("rst.o_d",    o_d,         64'd0);
        chk("rst.o_sid",  64'(o_sid),  64'd0);
        chk("rst.o_last", 64'(o_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release.i_r_before_edge", 64'(i_r), 64'd0);

        // Single beat, two-beat burst, stalled three-beat burst
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            i_v   = tbl[i].v;
            i_sid = tbl[i].sid;
            i_len = tbl[i].len;
            o_r   = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d.i_r", i), 64'(i_r), 64'(tbl[i].e_ir));
            chk($sformatf("v%0d.o_v", i), 64'(o_v), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("v%0d.o_d", i),    o_d,         tbl[i].e_d);
                chk($sformatf("v%0d.o_sid", i),  64'(o_sid),  64'(tbl[i].e_sid));
                chk($sformatf("v%0d.o_last", i), 64'(o_last), 64'(tbl[i].e_last));
            end
        end

        // Queue fills with downstream stalled, then drains back-to-back
        o_r = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_v = 1'b1; i_sid = 2'd0; i_len = 5'd1;
            #1;
            if (i_r) acc++;
        end
        @(negedge clk);
        i_v = 1'b0;
        #1;
        chk("full.accepted", 64'(acc), 64'd5);
        chk("full.i_r",      64'(i_r), 64'd0);
        chk("full.o_v_held", 64'(o_v), 64'd1);
        chk("full.o_d_held", o_d, word_of(3));
        o_r = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("drain%0d.o_v", j),    64'(o_v),    64'd1);
            chk($sformatf("drain%0d.o_d", j),    o_d,         word_of(3 + j));
            chk($sformatf("drain%0d.o_last", j), 64'(o_last), 64'd1);
            @(negedge clk);
            #1;
        end
        chk("drain.o_v_after", 64'(o_v), 64'd0);

        // Zero-length request is dropped, following request still plays
        beats = 0; dcap = '0; scap = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            i_v   = (c < 2);
            i_sid = 2'd2;
            i_len = (c == 0) ? 5'd0 : 5'd1;
            #1;
            if (c < 2) chk($sformatf("len0.i_r%0d", c), 64'(i_r), 64'd1);
            if (o_v) begin
                beats++;
                dcap = o_d;
                scap = o_sid;
            end
        end
        chk("len0.beats", 64'(beats), 64'd1);
        chk("len0.o_d",   dcap,       c_w0);
        chk("len0.o_sid", 64'(scap),  64'd2);

        // 33 beats on stream 3 (middle request clamped to 16), counter wraps
        beats = 0; lasts = 0; first_c = -1; last_c = -1;
        d32 = '0; d33 = '0; l16 = 1'b0; l33 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            i_v   = (c < 3);
            i_sid = 2'd3;
            i_len = (c == 0) ? 5'd16 : ((c == 1) ? 5'd31 : 5'd1);
            #1;
            if (c < 3) chk($sformatf("wrap.i_r%0d", c), 64'(i_r), 64'd1);
            if (o_v && o_r) begin
                beats++;
                if (first_c < 0) first_c = c;
                last_c = c;
                if (o_last) lasts++;
                if (beats == 16) l16 = o_last;
                if (beats == 32) d32 = o_d;
                if (beats == 33) begin
                    d33 = o_d;
                    l33 = o_last;
                end
            end
        end
        chk("wrap.beats",   64'(beats),            64'd33);
        chk("wrap.span",    64'(last_c - first_c), 64'd32);
        chk("wrap.lasts",   64'(lasts),            64'd3);
        chk("wrap.last16",  64'(l16),              64'd1);
        chk("wrap.beat32",  d32,                   64'hFFFEFDFCFBFAF9F8);
        chk("wrap.beat33",  d33,                   c_w0);
        chk("wrap.last33",  64'(l33),              64'd1);

        // Reset in the middle of an 8-beat burst
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            i_v = (c == 0); i_sid = 2'd0; i_len = 5'd8;
            #1;
            if (o_v) begin
                if (beats == 3) break;
                beats++;
            end
        end
        chk("midrst.beats_before", 64'(beats), 64'd3);
        chk("midrst.o_d_beat4",    o_d,        word_of(11));
        rst_n = 1'b0;
        i_v   = 1'b0;
        #1;
        chk("midrst.o_v",    64'(o_v),    64'd0);
        chk("midrst.i_r",    64'(i_r),    64'd0);
        chk("midrst.o_d",    o_d,         64'd0);
        chk("midrst.o_last", 64'(o_last), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        beats = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (c == 0) chk("midrst.i_r_after", 64'(i_r), 64'd1);
            if (o_v) beats++;
        end
        chk("midrst.no_stray_beats", 64'(beats), 64'd0);
        beats = 0; dcap = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_v = (c == 0); i_sid = 2'd0; i_len = 5'd1;
            #1;
            if (o_v) begin
                beats++;
                dcap = o_d;
            end
        end
        chk("midrst.new_beats", 64'(beats), 64'd1);
        chk("midrst.new_o_d",   dcap,       c_w0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wd_stream_driver.md
WD_STREAM_DRIVER -- requirements
Module: wd_stream_driver

Interface
REQ-001 SHALL have parameter WAYS, default 8, meaning data lanes per output word.
REQ-002 SHALL have parameter LANE_W, default 8, meaning bits per lane; o_d width = WAYS*LANE_W.
REQ-003 SHALL have parameter STREAMS, default 4, meaning independent stream counters.
REQ-004 SHALL have parameter MAX_LEN, default 16, meaning maximum beats per request; LEN_W = clog2(MAX_LEN+1).
REQ-005 SHALL have parameter QDEPTH, default 4, meaning request queue entries.
REQ-006 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 i_v  in  1  request valid.
REQ-009 i_r  out  1  request ready.
REQ-010 i_sid  in  clog2(STREAMS)  target stream.
REQ-011 i_len  in  LEN_W  beats requested.
REQ-012 o_v  out  1  data valid.
REQ-013 o_r  in  1  downstream ready.
REQ-014 o_d  out  WAYS*LANE_W  data word.
REQ-015 o_sid  out  clog2(STREAMS)  stream of current beat.
REQ-016 o_last  out  1  final beat of request.

Function
REQ-017 SHALL accept a request on a rising edge with i_v && i_r and write {i_sid, i_len} to a FIFO of QDEPTH entries.
REQ-018 SHALL drive i_r = queue not full, from registered state only; a full queue SHALL NOT accept even when popping that cycle.
REQ-019 SHALL run FSM states IDLE and BURST; IDLE with queue non-empty pops head, loads sid and remaining = len, enters BURST.
REQ-020 SHALL discard a popped request with len == 0 with no beats, staying in IDLE.
REQ-021 SHALL, in BURST, assert o_v; a beat transfers on edge with o_v && o_r.
REQ-022 SHALL form lane k (bits k*LANE_W upward) as low LANE_W bits of seq[sid]*WAYS + k, where seq[sid] is that stream's LANE_W-bit beat counter.
REQ-023 SHALL increment seq[sid] by 1 (wrapping modulo 2^LANE_W) per transferred beat; other streams' counters unchanged.
REQ-024 SHALL assert o_last when remaining == 1.
REQ-025 SHALL hold o_v, o_d, o_sid, o_last stable while o_v && !o_r.
REQ-026 SHALL, on the last beat's transfer, pop the next request in the same edge if queue non-empty (no bubble, unless len == 0), else return to IDLE.
REQ-027 SHALL give latency: request accepted at edge E0 into empty queue with IDLE FSM produces o_v high after edge E1.
REQ-028 SHALL allow simultaneous push and pop in one edge when queue neither full nor empty; count unchanged.
REQ-029 SHALL treat i_len > MAX_LEN as MAX_LEN.

Reset
REQ-030 SHALL, on reset low, asynchronously clear: FSM to IDLE, queue empty, all seq counters 0, o_v 0, o_last 0, o_d 0, o_sid 0.
REQ-031 SHALL drive i_r 0 while reset is low and 1 from the first edge after release.
REQ-032 SHALL abandon any in-flight burst and queued requests on reset mid-operation; no beat appears after release without a new request.

Structure
REQ-033 SHALL place default parameters, FSM state enum and the lane-value function in shared package wd_pkg.
REQ-034 SHALL implement the request queue as sub-module wd_req_fifo (parameters width, depth; push/pop/full/empty).

Verification
REQ-035 After reset, sid=0 len=1, o_r=1 -> one beat, o_d=0x0706050403020100, o_sid=0, o_last=1, o_v two edges after acceptance.
REQ-036 Then sid=0 len=2 -> o_d=0x0F0E0D0C0B0A0908 (o_last=0), then 0x1716151413121110 (o_last=1), consecutive cycles.
REQ-037 sid=1 len=3, o_r low 3 cycles after first beat -> o_d held at 0x0F0E..08 during stall, no beat skipped or repeated.
REQ-038 o_r=0, push 6 requests len=1 -> 5 accepted (1 in BURST, 4 queued), i_r low; releasing o_r drains 5 beats back-to-back.
REQ-039 sid=2 len=0 then sid=2 len=1 -> single beat 0x0706050403020100; 33 beats on sid=3 -> 33rd beat wraps to 0x0706050403020100.
REQ-040 Reset asserted mid-burst (sid=0 len=8, after 3 beats) -> o_v 0 immediately, i_r 0; after release no beats until new request, which restarts at 0x0706050403020100.
